uart_tx_main: RTL and testbench



---
 rtl/uart_tx_main.sv | 129 ++++++++++++
 tb/tb_uart_tx_main.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_main.sv
// -----------------------------------------------------------------------------
// uart_tx_main
//
// Byte-serialising UART transmitter. A trigger seen while idle captures q_in
// and sends it as one start bit (0), DATA_W data bits LSB first and one stop
// bit (1). The frame advances one bit per clk_en baud tick. The first tick
// after the trigger only aligns the frame, so the start bit always lasts a
// full tick interval.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   clk_en   baud tick; the frame advances one bit on edges where it is high
//   q_in     parallel data, sampled only when a trigger is accepted
//   trigger  transmit request, level-sampled on every clock edge
//   busy     high from request acceptance through the end of the stop bit
//   s_out    serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_main #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] q_in,
    input  logic              trigger,
    output logic              busy,
    output logic              s_out
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [IDX_W-1:0]  idx_inc;
    logic              s_out_next;
    logic              busy_next;

    // State and output registers; s_out and busy come straight from flops
    // so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            s_out <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            idx   <= idx_next;
            s_out <= s_out_next;
            busy  <= busy_next;
        end
    end

    assign idx_inc = idx + 1'b1;

    // Next-state logic. Every register holds by default, so edges with
    // clk_en low change nothing once a frame is under way.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = idx;
        s_out_next = s_out;
        busy_next  = busy;

        unique case (state)
            IDLE: begin
                // Acceptance does not wait for a baud tick.
                if (trigger) begin
                    shreg_next = q_in;
                    busy_next  = 1'b1;
                    s_out_next = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (clk_en) begin
                    s_out_next = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (clk_en) begin
                    idx_next   = '0;
                    s_out_next = shreg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (clk_en) begin
                    if (idx == LAST_IDX) begin
                        s_out_next = 1'b1;
                        state_next = STOP;
                    end else begin
                        idx_next   = idx_inc;
                        s_out_next = shreg[idx_inc];
                    end
                end
            end
            STOP: begin
                // Trigger is not looked at here, so a held request starts
                // the next frame one edge after IDLE is entered.
                if (clk_en) begin
                    busy_next  = 1'b0;
                    s_out_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                s_out_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_main.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_main
//
// Table-driven bench for uart_tx_main. Each record holds the inputs for one
// clock edge and the s_out/busy values expected just after that edge.
// Asynchronous reset cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_main;

    typedef struct {
        logic       en;
        logic       trig;
        logic [7:0] d;
        logic       exp_s;
        logic       exp_b;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic [7:0] q_in;
    logic       trigger;
    logic       busy;
    logic       s_out;

    int n_vec;
    int n_miss;
    vec_t vq[$];

    uart_tx_main #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .q_in    (q_in),
        .trigger (trigger),
        .busy    (busy),
        .s_out   (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic es, input logic eb);
        n_vec++;
        if (s_out !== es || busy !== eb) begin
            n_miss++;
            $display("FAIL %s: s_out=%b busy=%b, required s_out=%b busy=%b (t=%0t)",
                     nm, s_out, busy, es, eb, $time);
        end
    endtask

    task automatic add(input logic en, input logic trig, input logic [7:0] d,
                       input logic es, input logic eb, input string nm);
        vec_t v;
        v.en = en; v.trig = trig; v.d = d; v.exp_s = es; v.exp_b = eb; v.name = nm;
        vq.push_back(v);
    endtask

    // Applies every queued record on one edge each and compares just after it.
    task automatic run_vecs();
        foreach (vq[i]) begin
            clk_en  = vq[i].en;
            trigger = vq[i].trig;
            q_in    = vq[i].d;
            @(posedge clk);
            #1;
            check(vq[i].name, vq[i].exp_s, vq[i].exp_b);
        end
        vq.delete();
        clk_en  = 1'b1;
        trigger = 1'b0;
    endtask

    initial begin
        logic [7:0] v81;
        logic [7:0] v3c;
        logic [7:0] v55;
        n_vec   = 0;
        n_miss  = 0;
        rst_n   = 1'b0;
        clk_en  = 1'b1;
        trigger = 1'b0;
        q_in    = 8'h00;
        v81 = 8'h81;
        v3c = 8'h3C;
        v55 = 8'h55;

        #12;
        check("reset_state", 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 1'b1, 1'b0);

        // 0xF0 at full rate: E0 accept, E1 start, E2..E9 data, E10 stop, E11 idle.
        add(1, 1, 8'hF0, 1, 1, "f0_wait");
        add(1, 0, 8'h00, 0, 1, "f0_start");
        add(1, 0, 8'h00, 0, 1, "f0_d0");
        add(1, 0, 8'h00, 0, 1, "f0_d1");
        add(1, 0, 8'h00, 0, 1, "f0_d2");
        add(1, 0, 8'h00, 0, 1, "f0_d3");
        add(1, 0, 8'h00, 1, 1, "f0_d4");
        add(1, 0, 8'h00, 1, 1, "f0_d5");
        add(1, 0, 8'h00, 1, 1, "f0_d6");
        add(1, 0, 8'h00, 1, 1, "f0_d7");
        add(1, 0, 8'h00, 1, 1, "f0_stop");
        add(1, 0, 8'h00, 1, 0, "f0_idle");
        // E12..E22 idle, then 0x00 accepted on E23.
        for (int i = 0; i < 11; i++) add(1, 0, 8'hFF, 1, 0, "gap_idle");
        add(1, 1, 8'h00, 1, 1, "z_wait");
        add(1, 0, 8'hFF, 0, 1, "z_start");
        for (int i = 0; i < 8; i++) add(1, 0, 8'hFF, 0, 1, "z_data");
        add(1, 0, 8'hFF, 1, 1, "z_stop");
        add(1, 0, 8'hFF, 1, 0, "z_idle");
        add(1, 0, 8'hFF, 1, 0, "z_idle2");

        // 0x0F with a 0xAA request pulsed mid-frame: must be ignored.
        add(1, 1, 8'h0F, 1, 1, "of_wait");
        add(1, 0, 8'h0F, 0, 1, "of_start");
        add(1, 0, 8'h0F, 1, 1, "of_d0");
        add(1, 1, 8'hAA, 1, 1, "of_d1_trig");
        add(1, 0, 8'hAA, 1, 1, "of_d2");
        add(1, 0, 8'hAA, 1, 1, "of_d3");
        add(1, 0, 8'hAA, 0, 1, "of_d4");
        add(1, 0, 8'hAA, 0, 1, "of_d5");
        add(1, 0, 8'hAA, 0, 1, "of_d6");
        add(1, 0, 8'hAA, 0, 1, "of_d7");
        add(1, 0, 8'hAA, 1, 1, "of_stop");
        add(1, 0, 8'hAA, 1, 0, "of_idle");
        for (int i = 0; i < 4; i++) add(1, 0, 8'hAA, 1, 0, "of_no_second");

        // 0x55 with clk_en one cycle in four; accepted on a non-tick edge.
        add(0, 1, 8'h55, 1, 1, "sp_accept");
        add(0, 0, 8'h00, 1, 1, "sp_wait");
        add(0, 0, 8'h00, 1, 1, "sp_wait");
        for (int b = 0; b < 10; b++) begin
            logic bitv;
            if (b == 0)      bitv = 1'b0;
            else if (b == 9) bitv = 1'b1;
            else             bitv = v55[b-1];
            for (int k = 0; k < 4; k++) add((k == 0), 0, 8'h00, bitv, 1, "sp_bit");
        end
        add(1, 0, 8'h00, 1, 0, "sp_idle");

        // Trigger held high: 0x81 then 0x3C, busy low for exactly one edge.
        add(1, 1, 8'h81, 1, 1, "hh_wait1");
        add(1, 1, 8'hFF, 0, 1, "hh_start1");
        for (int i = 0; i < 8; i++) add(1, 1, 8'hFF, v81[i], 1, "hh_data1");
        add(1, 1, 8'hFF, 1, 1, "hh_stop1");
        add(1, 1, 8'hFF, 1, 0, "hh_gap");
        add(1, 1, 8'h3C, 1, 1, "hh_wait2");
        add(1, 1, 8'hFF, 0, 1, "hh_start2");
        for (int i = 0; i < 8; i++) add(1, 1, 8'hFF, v3c[i], 1, "hh_data2");
        add(1, 1, 8'hFF, 1, 1, "hh_stop2");
        add(1, 0, 8'hFF, 1, 0, "hh_idle");
        add(1, 0, 8'hFF, 1, 0, "hh_idle2");
        run_vecs();

        // Asynchronous reset while idle.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_idle_async", 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-frame while s_out is driving a 0 data bit.
        add(1, 1, 8'h00, 1, 1, "rf_wait");
        add(1, 0, 8'h00, 0, 1, "rf_start");
        add(1, 0, 8'h00, 0, 1, "rf_d0");
        add(1, 0, 8'h00, 0, 1, "rf_d1");
        run_vecs();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_frame_async", 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) add(1, 0, 8'h00, 1, 0, "rf_after_idle");
        run_vecs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
